pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch front end that sits directly upstream of the instruction ROM. It owns the program counter and drives the ROM's chip-enable and address. It captures each returned instruction word together with its PC into a small fetch buffer and presents them to the decode stage through a valid/ready handshake. Branch and jump redirects from later stages flush the buffer and reload the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `FIFO_DEPTH`, default 2: fetch buffer entries; power of two, at least 2.

- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `redirect_i`  in  1: load a new PC and flush the buffer.
- `redirect_pc_i`  in  32 (`InstAddrBus`): redirect target.
- `ce_o`  out  1: ROM chip enable, `ChipEnable`/`ChipDisable`.
- `pc_o`  out  32 (`InstAddrBus`): ROM byte address.
- `inst_i`  in  32 (`InstBus`): ROM data; combinational in the same cycle as `pc_o`.
- `if_valid_o`  out  1: buffer head is valid.
- `if_pc_o`  out  32: PC of the head entry.
- `if_inst_o`  out  32: instruction of the head entry.
- `id_ready_i`  in  1: decode accepts the head this cycle.

## Operation
- Two-state FSM.
  - IDLE is entered on reset and lasts exactly one cycle; the FSM then moves unconditionally to FETCH.
  - FETCH persists until the next reset.
- ce_o = (state == FETCH) && (count < FIFO_DEPTH) && !redirect_i. When ce_o is 0, the ROM outputs `ZeroWord`.
- Push: on a clock edge with ce_o = 1, write {pc_o, inst_i} to the tail and set pc_o <= pc_o + 4.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- Pop: on a clock edge with if_valid_o && id_ready_i && !redirect_i, the head retires.
- Push and pop in the same cycle leave count unchanged. Count width is clog2(FIFO_DEPTH)+1.
- Full buffer: ce_o drops and pc_o holds. There is no same-cycle bypass, so a pop frees a slot for the next cycle.
- Redirect has highest priority:
  - count <= 0 and pc_o <= {redirect_pc_i[31:2], 2'b00}. Misaligned low bits are silently cleared.
  - No push occurs that cycle.
  - A head presented in that cycle is wrong-path; decode must not treat it as accepted.
- Redirect during IDLE loads the PC; the FSM still proceeds to FETCH on the next cycle.
- Head outputs: if_valid_o = (count != 0). When the buffer is empty, if_pc_o = 0 and if_inst_o = `ZeroWord` (a nop).

## Timing
- Reset values:
  - state = IDLE, count = 0.
  - ce_o = 0, pc_o = RESET_PC.
  - if_valid_o = 0, if_pc_o = 0, if_inst_o = 0.
- Reset assertion clears everything asynchronously, including in the middle of a fetch or with the buffer full.
- Startup sequence after reset deasserts:
  - Cycle 0: IDLE, ce_o = 0.
  - Cycle 1: ce_o = 1, pc_o = RESET_PC.
  - Cycle 2: if_valid_o = 1 with if_pc_o = RESET_PC.
- Redirect latency: redirect in cycle n gives pc_o = target and if_valid_o = 0 in cycle n+1. The target instruction is at the head in cycle n+2.
- Throughput: with id_ready_i held high, one instruction per cycle and steady-state count = 1.
- Backpressure: with id_ready_i low, the buffer fills to FIFO_DEPTH, then ce_o = 0 and pc_o is frozen.
- Head outputs come directly from buffer registers, with no combinational path from inst_i.

## Structure
- Shared `defines.vh` already holds `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`, `ChipDisable`.
- Add `RstActive` (1'b0) to `defines.vh` for this block.
- Add `PcStep` (32'd4) to `defines.vh`.
- One sub-module, `fetch_fifo`:
  - Parameterised depth and width 64, holding {pc, inst}.
  - Ports: push, pop, flush, count, head.
  - Contains the read/write pointers with wrap-around.
- The PC register, FSM and ce_o logic stay in `pc_fetch`.

## Test plan
- Reset release with ROM words 0x0000_0000..: ce_o = 0 in cycle 0 and 1 in cycle 1. In cycle 2, if_valid_o = 1, if_pc_o = 0, if_inst_o = mem[0].
- id_ready_i held high for 8 cycles: if_pc_o steps 0, 4, 8, … with one instruction per cycle and no bubbles.
- id_ready_i held low for 5 cycles: count saturates at 2, ce_o = 0, pc_o frozen at 8. id_ready_i then rises: the entries with PC 0 and 4 are delivered in order, then PC 8.
- Redirect to 32'h0000_0043 while the buffer is full: next cycle if_valid_o = 0 and pc_o = 32'h0000_0040. The cycle after that, the head is {0x40, mem[16]}. Stale entries never appear.
- RESET_PC = 32'hFFFF_FFF8 with continuous accept: heads are 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- rst asserted mid-stream with count = 1: all outputs return to their reset values immediately, without waiting for a clock edge. Fetch restarts from RESET_PC.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package pc_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0]     ZeroWord    = 32'h0000_0000;
  localparam logic                   ChipEnable  = 1'b1;
  localparam logic                   ChipDisable = 1'b0;
  localparam logic                   RstActive   = 1'b0;
  localparam logic [InstAddrBus-1:0] PcStep      = 32'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // One fetch buffer entry: the byte address and the word read from it.
  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  // Instructions are word aligned; stray low address bits are dropped.
  function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small circular buffer of {pc, inst} entries with flush
module fetch_fifo
  import pc_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Never overfill or underflow, whatever the caller asks for.
  assign do_push = push && (cnt != DEPTH_C);
  assign do_pop  = pop && (cnt != '0);

  // Pointers wrap naturally because DEPTH is a power of two; flush empties in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActive) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once cnt covers it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign count = cnt;
  assign head  = (cnt != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter, ROM enable and fetch buffer feeding decode
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_i,
  input  logic [InstAddrBus-1:0] redirect_pc_i,
  output logic                   ce_o,
  output logic [InstAddrBus-1:0] pc_o,
  input  logic [InstBus-1:0]     inst_i,
  output logic                   if_valid_o,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o,
  input  logic                   id_ready_i
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t               state;
  logic [InstAddrBus-1:0]     pc_q;
  logic [CW-1:0]              count;
  logic [63:0]                head;
  fetch_entry_t               head_entry;
  logic                       fetch_en;
  logic                       pop;

  // Fetch only when running, with room in the buffer, and not on a redirect cycle.
  assign fetch_en = (state == FETCH) && (count < DEPTH_C) && !redirect_i;
  assign ce_o     = fetch_en ? ChipEnable : ChipDisable;
  assign pc_o     = pc_q;

  // A head shown during a redirect is wrong-path and is flushed, not retired.
  assign pop = if_valid_o && id_ready_i && !redirect_i;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fetch_en),
    .pop       (pop),
    .flush     (redirect_i),
    .push_data ({pc_q, inst_i}),
    .count     (count),
    .head      (head)
  );

  assign head_entry = fetch_entry_t'(head);
  assign if_valid_o = (count != '0);
  assign if_pc_o    = head_entry.pc;
  assign if_inst_o  = head_entry.inst;

  // One idle cycle after reset, then fetch until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActive) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  // Redirect wins over sequential advance; the PC holds while the buffer is full.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActive) begin
      pc_q <= RESET_PC;
    end else if (redirect_i) begin
      pc_q <= align_pc(redirect_pc_i);
    end else if (fetch_en) begin
      pc_q <= pc_q + PcStep;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - self-checking bench for pc_fetch with a queue-level fetch model
module tb_pc_fetch;

  localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;

  logic        ce0, ce1, v0, v1;
  logic [31:0] pc0, pc1, inst0, inst1, ipc0, ipc1, iin0, iin1;

  int checks;
  int errors;

  // ROM contents: every word is distinguishable from its address and from zero.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  assign inst0 = ce0 ? rom_word(pc0) : 32'h0;
  assign inst1 = ce1 ? rom_word(pc1) : 32'h0;

  pc_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .ce_o(ce0), .pc_o(pc0), .inst_i(inst0),
    .if_valid_o(v0), .if_pc_o(ipc0), .if_inst_o(iin0), .id_ready_i(ready)
  );

  pc_fetch #(.RESET_PC(RPC1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .ce_o(ce1), .pc_o(pc1), .inst_i(inst1),
    .if_valid_o(v1), .if_pc_o(ipc1), .if_inst_o(iin1), .id_ready_i(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc [2];
  logic [63:0] m_q  [2][0:3];
  int          m_sz [2];
  int          m_since;
  logic        m_fire;
  logic [63:0] m_new;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_since = 0;
      for (int k = 0; k < 2; k++) begin
        m_sz[k] = 0;
        m_pc[k] = (k == 0) ? 32'h0 : RPC1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_fire = (m_since >= 1) && (m_sz[k] < DEPTH) && !redirect;
        if (redirect) begin
          m_sz[k] = 0;
          m_pc[k] = {redirect_pc[31:2], 2'b00};
        end else begin
          m_new = {m_pc[k], rom_word(m_pc[k])};
          if (m_sz[k] > 0 && ready) begin
            for (int j = 0; j < 3; j++) m_q[k][j] = m_q[k][j+1];
            m_sz[k] = m_sz[k] - 1;
          end
          if (m_fire) begin
            m_q[k][m_sz[k]] = m_new;
            m_sz[k] = m_sz[k] + 1;
            m_pc[k] = m_pc[k] + 32'd4;
          end
        end
      end
      if (m_since < 2) m_since = m_since + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int k, input logic ce, input logic [31:0] pc, input logic v,
                         input logic [31:0] ipc, input logic [31:0] iin);
    logic        e_ce;
    logic [63:0] e_head;
    e_ce   = rst && (m_since >= 1) && (m_sz[k] < DEPTH) && !redirect;
    e_head = (m_sz[k] > 0) ? m_q[k][0] : 64'h0;
    chk($sformatf("model%0d ce_o", k), {31'h0, ce}, {31'h0, e_ce});
    chk($sformatf("model%0d pc_o", k), pc, m_pc[k]);
    chk($sformatf("model%0d if_valid_o", k), {31'h0, v}, (m_sz[k] > 0) ? 32'h1 : 32'h0);
    chk($sformatf("model%0d if_pc_o", k), ipc, e_head[63:32]);
    chk($sformatf("model%0d if_inst_o", k), iin, e_head[31:0]);
  endtask

  // Compare both DUTs against the model away from the active edge.
  always @(negedge clk) begin
    cmp_dut(0, ce0, pc0, v0, ipc0, iin0);
    cmp_dut(1, ce1, pc1, v1, ipc1, iin1);
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ready       = 1'b1;

    step;
    step;
    chk("reset ce_o", {31'h0, ce0}, 32'h0);
    chk("reset pc_o", pc0, 32'h0);
    chk("reset if_valid_o", {31'h0, v0}, 32'h0);
    chk("reset if_pc_o", ipc0, 32'h0);
    chk("reset if_inst_o", iin0, 32'h0);
    chk("reset pc_o dut1", pc1, 32'hFFFF_FFF8);

    // startup sequence
    rst = 1'b1;
    #1;
    chk("cycle0 ce_o", {31'h0, ce0}, 32'h0);
    step;
    chk("cycle1 ce_o", {31'h0, ce0}, 32'h1);
    chk("cycle1 pc_o", pc0, 32'h0);
    step;
    chk("cycle2 if_valid_o", {31'h0, v0}, 32'h1);
    chk("cycle2 if_pc_o", ipc0, 32'h0);
    chk("cycle2 if_inst_o", iin0, 32'h5A5A_0000);

    // streaming with decode always ready
    for (int k = 1; k < 8; k++) begin
      step;
      chk("stream if_valid_o", {31'h0, v0}, 32'h1);
      chk("stream if_pc_o", ipc0, 32'(4 * k));
    end

    // restart at 0 and apply backpressure
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    ready       = 1'b0;
    #1;
    chk("redirect cycle ce_o", {31'h0, ce0}, 32'h0);
    step;
    redirect = 1'b0;
    #1;
    chk("after redirect if_valid_o", {31'h0, v0}, 32'h0);
    chk("after redirect pc_o", pc0, 32'h0);
    step;
    step;
    chk("full ce_o", {31'h0, ce0}, 32'h0);
    chk("full pc_o", pc0, 32'h8);
    chk("full if_pc_o", ipc0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step;
      chk("frozen pc_o", pc0, 32'h8);
      chk("frozen if_pc_o", ipc0, 32'h0);
    end
    ready = 1'b1;
    #1;
    chk("drain head0", ipc0, 32'h0);
    step;
    chk("drain head1", ipc0, 32'h4);
    step;
    chk("drain head2", ipc0, 32'h8);

    // fill again, then redirect to a misaligned target
    ready = 1'b0;
    step;
    chk("refill ce_o", {31'h0, ce0}, 32'h0);
    chk("refill pc_o", pc0, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    step;
    redirect = 1'b0;
    #1;
    chk("misaligned if_valid_o", {31'h0, v0}, 32'h0);
    chk("misaligned pc_o", pc0, 32'h40);
    ready = 1'b1;
    step;
    chk("target if_pc_o", ipc0, 32'h40);
    chk("target if_inst_o", iin0, 32'h5A5A_0040);
    step;
    chk("target+4 if_pc_o", ipc0, 32'h44);

    // asynchronous reset mid-stream
    #1;
    rst = 1'b0;
    #1;
    chk("async ce_o", {31'h0, ce0}, 32'h0);
    chk("async pc_o", pc0, 32'h0);
    chk("async if_valid_o", {31'h0, v0}, 32'h0);
    chk("async if_pc_o", ipc0, 32'h0);
    chk("async if_inst_o", iin0, 32'h0);
    chk("async pc_o dut1", pc1, 32'hFFFF_FFF8);
    chk("async if_valid_o dut1", {31'h0, v1}, 32'h0);
    step;
    step;
    rst = 1'b1;

    // wrap-around from a high reset PC
    #1;
    chk("wrap cycle0 ce_o", {31'h0, ce1}, 32'h0);
    step;
    chk("wrap cycle1 ce_o", {31'h0, ce1}, 32'h1);
    chk("wrap cycle1 pc_o", pc1, 32'hFFFF_FFF8);
    step;
    chk("wrap head0", ipc1, 32'hFFFF_FFF8);
    chk("restart head dut0", ipc0, 32'h0);
    step;
    chk("wrap head1", ipc1, 32'hFFFF_FFFC);
    step;
    chk("wrap head2", ipc1, 32'h0000_0000);
    chk("wrap inst2", iin1, 32'h5A5A_0000);
    step;
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
